// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice control path.
// The step entry layout matches the 8-bit pattern write word.
package synth_pkg;

    localparam logic [7:0] STEP_REST_DEFAULT = 8'h02;
    localparam int         MIN_TEMPO         = 4;

    typedef struct packed {
        logic [3:0] freq;
        logic [1:0] len;
        logic       rest;
        logic       wave;
    } step_entry_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GATE_ON  = 2'd1,
        S_GATE_OFF = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seq_step_store.sv
// Pattern register file: one write port, one combinational read port.
// Every entry resets to a rest step so an unprogrammed loop stays silent.
module seq_step_store
    import synth_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int AW    = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output step_entry_t   rd_data_o
);

    logic [7:0] mem_q [STEPS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_q[i] <= STEP_REST_DEFAULT;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = step_entry_t'(mem_q[rd_addr_i]);

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving tone code, waveform select and envelope gate of the voice.
// Entry fields and tempo are captured only at step load, so mid-step edits wait for the next pass.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS      = 8,
    parameter int FREQ_BITS  = 4,
    parameter int TEMPO_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     run,
    input  logic [TEMPO_BITS-1:0]    tempo,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    output logic [FREQ_BITS-1:0]     tone_freq_bin,
    output logic                     waveform_enable,
    output logic                     hold,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_strobe,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(STEPS);

    seq_state_t            state_q;
    logic [TEMPO_BITS-1:0] tick_cnt_q;
    logic [TEMPO_BITS-1:0] tempo_q;
    logic [TEMPO_BITS-1:0] gate_q;
    logic                  tie_q;

    logic [AW-1:0]         rd_addr;
    step_entry_t           rd_entry;
    logic [TEMPO_BITS-1:0] tempo_eff;
    logic [TEMPO_BITS-1:0] quarter;
    logic [TEMPO_BITS-1:0] len_plus1;
    logic [TEMPO_BITS-1:0] gate_d;
    logic [TEMPO_BITS-1:0] tick_cnt_d;
    logic                  boundary;

    // The read port always points at the step that the next load will use.
    assign rd_addr    = (state_q == S_IDLE) ? '0 : step_idx + 1'b1;
    assign tempo_eff  = (tempo < TEMPO_BITS'(MIN_TEMPO)) ? TEMPO_BITS'(MIN_TEMPO) : tempo;
    assign quarter    = tempo_eff >> 2;
    assign len_plus1  = TEMPO_BITS'(rd_entry.len) + TEMPO_BITS'(1);
    assign gate_d     = quarter * len_plus1;
    assign tick_cnt_d = tick_cnt_q + 1'b1;
    assign boundary   = (state_q == S_IDLE) || (tick_cnt_q == tempo_q - 1'b1);
    assign dbg_state  = state_q;

    seq_step_store #(.STEPS(STEPS)) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            tick_cnt_q      <= '0;
            tempo_q         <= TEMPO_BITS'(MIN_TEMPO);
            gate_q          <= '0;
            tie_q           <= 1'b0;
            tone_freq_bin   <= '0;
            waveform_enable <= 1'b0;
            hold            <= 1'b0;
            step_idx        <= '0;
            step_strobe     <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            if (!run) begin
                state_q    <= S_IDLE;
                tick_cnt_q <= '0;
                hold       <= 1'b0;
                step_idx   <= '0;
            end else if (tick) begin
                if (boundary) begin
                    tone_freq_bin   <= FREQ_BITS'(rd_entry.freq);
                    waveform_enable <= rd_entry.wave;
                    step_idx        <= rd_addr;
                    step_strobe     <= 1'b1;
                    tick_cnt_q      <= '0;
                    tempo_q         <= tempo_eff;
                    gate_q          <= gate_d;
                    tie_q           <= (rd_entry.len == 2'd3);
                    hold            <= !rd_entry.rest;
                    state_q         <= rd_entry.rest ? S_GATE_OFF : S_GATE_ON;
                end else begin
                    tick_cnt_q <= tick_cnt_d;
                    // A tied step keeps the gate up into the next step (legato).
                    if (state_q == S_GATE_ON && !tie_q && tick_cnt_d == gate_q) begin
                        hold    <= 1'b0;
                        state_q <= S_GATE_OFF;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one task per scenario, inline checks.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic [11:0] tempo = 12'd8;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  tone_freq_bin;
    logic        waveform_enable;
    logic        hold;
    logic [2:0]  step_idx;
    logic        step_strobe;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    note_sequencer #(.STEPS(8), .FREQ_BITS(4), .TEMPO_BITS(12)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .run             (run),
        .tempo           (tempo),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .tone_freq_bin   (tone_freq_bin),
        .waveform_enable (waveform_enable),
        .hold            (hold),
        .step_idx        (step_idx),
        .step_strobe     (step_strobe),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int strobe_seen;
        int hold_seen;
        rst_n = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tone_freq_bin !== 4'd0) begin errors++; $display("FAIL reset_tone: got %0h expected 0", tone_freq_bin); end
        checks++; if (waveform_enable !== 1'b0) begin errors++; $display("FAIL reset_wave: got %0b expected 0", waveform_enable); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %0b expected 0", hold); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", step_idx); end
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b expected 0", step_strobe); end
        rst_n = 1'b1;
        strobe_seen = 0;
        hold_seen = 0;
        repeat (5) begin
            do_tick();
            if (step_strobe === 1'b1) strobe_seen++;
            if (hold === 1'b1) hold_seen++;
        end
        checks++; if (strobe_seen !== 0) begin errors++; $display("FAIL idle_strobe: got %0d pulses expected 0", strobe_seen); end
        checks++; if (hold_seen !== 0) begin errors++; $display("FAIL idle_hold: got %0d high samples expected 0", hold_seen); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_basic_gate();
        int hold_cnt;
        int strobe_cnt;
        do_write(3'd0, 8'h50);
        tempo = 12'd8;
        run = 1'b1;
        do_tick();
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe0: got %0b expected 1", step_strobe); end
        checks++; if (tone_freq_bin !== 4'd5) begin errors++; $display("FAIL basic_tone0: got %0h expected 5", tone_freq_bin); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL basic_hold0: got %0b expected 1", hold); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL basic_idx0: got %0d expected 0", step_idx); end
        hold_cnt = 1;
        repeat (7) begin
            do_tick();
            if (hold === 1'b1) hold_cnt++;
        end
        checks++; if (hold_cnt !== 2) begin errors++; $display("FAIL basic_gate_len: got %0d ticks expected 2", hold_cnt); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL basic_state_off: got %0d expected 2", dbg_state); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL basic_idx_still0: got %0d expected 0", step_idx); end
        do_tick();
        checks++; if (step_idx !== 3'd1) begin errors++; $display("FAIL basic_idx1: got %0d expected 1", step_idx); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL basic_rest_hold: got %0b expected 0", hold); end
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe1: got %0b expected 1", step_strobe); end
        checks++; if (tone_freq_bin !== 4'd0) begin errors++; $display("FAIL basic_rest_tone: got %0h expected 0", tone_freq_bin); end
        strobe_cnt = 0;
        repeat (56) begin
            do_tick();
            if (step_strobe === 1'b1) strobe_cnt++;
        end
        checks++; if (strobe_cnt !== 7) begin errors++; $display("FAIL basic_strobe_count: got %0d expected 7", strobe_cnt); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL basic_wrap_idx: got %0d expected 0", step_idx); end
        checks++; if (tone_freq_bin !== 4'd5) begin errors++; $display("FAIL basic_wrap_tone: got %0h expected 5", tone_freq_bin); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL basic_wrap_hold: got %0b expected 1", hold); end
        run = 1'b0;
        @(negedge clk);
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL basic_stop_hold: got %0b expected 0", hold); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL basic_stop_state: got %0d expected 0", dbg_state); end
        checks++; if (tone_freq_bin !== 4'd5) begin errors++; $display("FAIL basic_stop_tone_kept: got %0h expected 5", tone_freq_bin); end
    endtask

    task automatic test_tie();
        int hold_low;
        do_write(3'd0, 8'h3C);
        do_write(3'd1, 8'h74);
        tempo = 12'd8;
        run = 1'b1;
        do_tick();
        checks++; if (tone_freq_bin !== 4'd3) begin errors++; $display("FAIL tie_tone0: got %0h expected 3", tone_freq_bin); end
        hold_low = 0;
        repeat (7) begin
            do_tick();
            if (hold !== 1'b1) hold_low++;
        end
        checks++; if (hold_low !== 0) begin errors++; $display("FAIL tie_hold_step0: got %0d low ticks expected 0", hold_low); end
        do_tick();
        checks++; if (step_idx !== 3'd1) begin errors++; $display("FAIL tie_idx1: got %0d expected 1", step_idx); end
        checks++; if (tone_freq_bin !== 4'd7) begin errors++; $display("FAIL tie_tone1: got %0h expected 7", tone_freq_bin); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL tie_hold_boundary: got %0b expected 1", hold); end
        repeat (3) do_tick();
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL tie_hold_tick3: got %0b expected 1", hold); end
        do_tick();
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL tie_hold_tick4: got %0b expected 0", hold); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL tie_state_off: got %0d expected 2", dbg_state); end
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tempo_clamp();
        do_write(3'd0, 8'h91);
        tempo = 12'd1;
        run = 1'b1;
        do_tick();
        checks++; if (tone_freq_bin !== 4'd9) begin errors++; $display("FAIL clamp_tone: got %0h expected 9", tone_freq_bin); end
        checks++; if (waveform_enable !== 1'b1) begin errors++; $display("FAIL clamp_wave: got %0b expected 1", waveform_enable); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL clamp_hold_on: got %0b expected 1", hold); end
        do_tick();
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL clamp_gate_1tick: got %0b expected 0", hold); end
        repeat (2) do_tick();
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL clamp_idx_tick3: got %0d expected 0", step_idx); end
        do_tick();
        checks++; if (step_idx !== 3'd1) begin errors++; $display("FAIL clamp_idx_tick4: got %0d expected 1", step_idx); end
        checks++; if (waveform_enable !== 1'b0) begin errors++; $display("FAIL clamp_wave1: got %0b expected 0", waveform_enable); end
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL clamp_hold_step1: got %0b expected 1", hold); end
        run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_abort();
        do_write(3'd2, 8'hA8);
        tempo = 12'd8;
        run = 1'b1;
        do_tick();
        repeat (16) do_tick();
        checks++; if (step_idx !== 3'd2) begin errors++; $display("FAIL abort_idx2: got %0d expected 2", step_idx); end
        checks++; if (tone_freq_bin !== 4'hA) begin errors++; $display("FAIL abort_tone2: got %0h expected a", tone_freq_bin); end
        repeat (3) do_tick();
        checks++; if (hold !== 1'b1) begin errors++; $display("FAIL abort_hold_tick3: got %0b expected 1", hold); end
        run = 1'b0;
        @(negedge clk);
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL abort_hold: got %0b expected 0", hold); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL abort_idx: got %0d expected 0", step_idx); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", dbg_state); end
        checks++; if (tone_freq_bin !== 4'hA) begin errors++; $display("FAIL abort_tone_kept: got %0h expected a", tone_freq_bin); end
        do_tick();
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL abort_tick_ignored: got %0b expected 0", step_strobe); end
        run = 1'b1;
        do_tick();
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL restart_strobe: got %0b expected 1", step_strobe); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL restart_idx: got %0d expected 0", step_idx); end
        checks++; if (tone_freq_bin !== 4'd9) begin errors++; $display("FAIL restart_tone: got %0h expected 9", tone_freq_bin); end
    endtask

    task automatic test_write_playing();
        repeat (8) do_tick();
        checks++; if (tone_freq_bin !== 4'd7) begin errors++; $display("FAIL wr_play_tone_before: got %0h expected 7", tone_freq_bin); end
        do_write(3'd1, 8'hC4);
        checks++; if (tone_freq_bin !== 4'd7) begin errors++; $display("FAIL wr_play_tone_kept: got %0h expected 7", tone_freq_bin); end
        checks++; if (step_idx !== 3'd1) begin errors++; $display("FAIL wr_play_idx_kept: got %0d expected 1", step_idx); end
        repeat (64) do_tick();
        checks++; if (step_idx !== 3'd1) begin errors++; $display("FAIL wr_play_next_idx: got %0d expected 1", step_idx); end
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL wr_play_next_strobe: got %0b expected 1", step_strobe); end
        checks++; if (tone_freq_bin !== 4'hC) begin errors++; $display("FAIL wr_play_next_tone: got %0h expected c", tone_freq_bin); end
    endtask

    task automatic test_reset_mid_play();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL midrst_hold: got %0b expected 0", hold); end
        checks++; if (tone_freq_bin !== 4'd0) begin errors++; $display("FAIL midrst_tone: got %0h expected 0", tone_freq_bin); end
        checks++; if (step_idx !== 3'd0) begin errors++; $display("FAIL midrst_idx: got %0d expected 0", step_idx); end
        rst_n = 1'b1;
        do_tick();
        checks++; if (step_strobe !== 1'b1) begin errors++; $display("FAIL midrst_reload_strobe: got %0b expected 1", step_strobe); end
        checks++; if (hold !== 1'b0) begin errors++; $display("FAIL midrst_pattern_lost: got %0b expected 0", hold); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL midrst_state: got %0d expected 2", dbg_state); end
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_gate();
        test_tie();
        test_tempo_clamp();
        test_run_abort();
        test_write_playing();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
